// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed driver for a bank of common-anode
// seven-segment digits showing a 64-bit block as 16 hex nibbles, DIGITS at
// a time (one "page").
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   data_i[63:0] block to display, nibble k = data_i[4k+3:4k]
//   load_i       strobe: latch data_i into the shadow register, go to page 0
//   page_next_i  strobe: advance to the next page (wraps)
//   nibble_o[3:0]        nibble for the external hex-to-segment decoder
//   an_o[DIGITS-1:0]     digit enables, active-low
//   dp_o         decimal point, active-low (lit on the leftmost digit of page 0)
//   page_o[3:0]  current page index
//
// Optional feature: define SEG_AUTO_PAGE_EN to advance the page automatically
// every PAGE_DIV complete scans.

module hex_scan_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned BLANK    = 2,
    parameter int unsigned PAGE_DIV = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [63:0]       data_i,
    input  logic              load_i,
    input  logic              page_next_i,
    output logic [3:0]        nibble_o,
    output logic [DIGITS-1:0] an_o,
    output logic              dp_o,
    output logic [3:0]        page_o
);

    localparam int unsigned NP    = 16 / DIGITS;
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PG_W  = (NP > 1) ? $clog2(NP) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);
    localparam logic [PG_W-1:0]  PG_LAST   = PG_W'(NP - 1);

`ifdef SEG_AUTO_PAGE_EN
    localparam int unsigned SC_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(PAGE_DIV - 1);
`endif

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic [PG_W-1:0]   page_q, page_d;
    logic [PG_W-1:0]   page_inc;
    logic [63:0]       sh_q, sh_d;
    logic [3:0]        nib_idx;
    logic [DIGITS-1:0] an_d;
    logic [3:0]        nibble_d;
    logic              dp_d;
    logic [3:0]        page_o_d;
`ifdef SEG_AUTO_PAGE_EN
    logic [SC_W-1:0]   scan_q, scan_d;
    logic              scan_wrap;
`endif

    // State, counters, shadow register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            digit_q  <= '0;
            page_q   <= '0;
            sh_q     <= '0;
            an_o     <= '1;
            nibble_o <= '0;
            dp_o     <= 1'b1;
            page_o   <= '0;
`ifdef SEG_AUTO_PAGE_EN
            scan_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            page_q   <= page_d;
            sh_q     <= sh_d;
            an_o     <= an_d;
            nibble_o <= nibble_d;
            dp_o     <= dp_d;
            page_o   <= page_o_d;
`ifdef SEG_AUTO_PAGE_EN
            scan_q   <= scan_d;
`endif
        end
    end

    // Next state, counters, and next output values from the current registers
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        page_d   = page_q;
        sh_d     = sh_q;
        page_inc = (page_q == PG_LAST) ? '0 : page_q + 1'b1;
`ifdef SEG_AUTO_PAGE_EN
        scan_d    = scan_q;
        scan_wrap = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (load_i) begin
                    state_d = SCAN;
                    sh_d    = data_i;
                    page_d  = '0;
                end
            end
            SCAN: begin
                // Slot/digit counters free-run; a load does not restart them
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
`ifdef SEG_AUTO_PAGE_EN
                    scan_wrap = (digit_q == DIG_LAST);
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                // Load has priority over a page step in the same cycle
                if (load_i) begin
                    sh_d   = data_i;
                    page_d = '0;
`ifdef SEG_AUTO_PAGE_EN
                    scan_d = '0;
`endif
                end else if (page_next_i) begin
                    page_d = page_inc;
`ifdef SEG_AUTO_PAGE_EN
                    scan_d = '0;
`endif
                end
`ifdef SEG_AUTO_PAGE_EN
                else if (scan_wrap) begin
                    if (scan_q == SC_LAST) begin
                        page_d = page_inc;
                        scan_d = '0;
                    end else begin
                        scan_d = scan_q + 1'b1;
                    end
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Blank window at the start of each slot keeps all digits dark
        an_d = '1;
        if ((state_q == SCAN) && (cnt_q >= CNT_BLANK)) begin
            an_d[digit_q] = 1'b0;
        end

        nib_idx  = 4'(32'(page_q) * DIGITS + 32'(digit_q));
        nibble_d = sh_q[{nib_idx, 2'b00} +: 4];
        dp_d     = ~(~an_d[DIGITS-1] & (page_q == '0));
        page_o_d = 4'(page_q);
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl: a stimulus process drives inputs and
// pushes the expected registered outputs from a time-based reference model;
// a monitor pops and compares every clock.

module tb_hex_scan_ctrl;

    localparam int unsigned D  = 4;
    localparam int unsigned SD = 8;
    localparam int unsigned BL = 2;
    localparam int unsigned PD = 2;
    localparam int unsigned NP = 16 / D;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [63:0]  data_i;
    logic         load_i;
    logic         page_next_i;
    logic [3:0]   nibble_o;
    logic [D-1:0] an_o;
    logic         dp_o;
    logic [3:0]   page_o;

    hex_scan_ctrl #(
        .DIGITS   (D),
        .SCAN_DIV (SD),
        .BLANK    (BL),
        .PAGE_DIV (PD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .load_i      (load_i),
        .page_next_i (page_next_i),
        .nibble_o    (nibble_o),
        .an_o        (an_o),
        .dp_o        (dp_o),
        .page_o      (page_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [D-1:0] an;
        logic [3:0]   nib;
        logic         dp;
        logic [3:0]   page;
    } obs_t;

    obs_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: a single time-in-scan counter plus page and block
    bit          m_scan;
    int          m_t;
    int          m_page;
    logic [63:0] m_sh;
`ifdef SEG_AUTO_PAGE_EN
    int          m_scans;
`endif

    task automatic model_reset();
        m_scan = 1'b0;
        m_t    = 0;
        m_page = 0;
        m_sh   = '0;
`ifdef SEG_AUTO_PAGE_EN
        m_scans = 0;
`endif
    endtask

    function automatic obs_t model_out();
        obs_t         o;
        int           slot;
        int           phase;
        bit           lit;
        logic [D-1:0] one;
        logic [63:0]  shifted;
        slot    = m_t / SD;
        phase   = m_t % SD;
        lit     = m_scan && (phase >= BL);
        one     = 1;
        o.an    = lit ? ~(one << slot) : '1;
        shifted = m_sh >> (4 * (m_page * D + slot));
        o.nib   = shifted[3:0];
        o.dp    = !(lit && (slot == D - 1) && (m_page == 0));
        o.page  = 4'(m_page);
        return o;
    endfunction

    task automatic model_step(input bit ld, input bit pn, input logic [63:0] d);
`ifdef SEG_AUTO_PAGE_EN
        bit wrapped;
        wrapped = m_scan && (m_t == D * SD - 1);
`endif
        if (!m_scan) begin
            if (ld) begin
                m_scan = 1'b1;
                m_sh   = d;
                m_page = 0;
                m_t    = 0;
            end
        end else begin
            m_t = (m_t + 1) % (D * SD);
            if (ld) begin
                m_sh   = d;
                m_page = 0;
`ifdef SEG_AUTO_PAGE_EN
                m_scans = 0;
`endif
            end else if (pn) begin
                m_page = (m_page + 1) % NP;
`ifdef SEG_AUTO_PAGE_EN
                m_scans = 0;
`endif
            end
`ifdef SEG_AUTO_PAGE_EN
            else if (wrapped) begin
                m_scans++;
                if (m_scans == PD) begin
                    m_scans = 0;
                    m_page  = (m_page + 1) % NP;
                end
            end
`endif
        end
    endtask

    // One clock of stimulus: expected outputs after the next edge come from
    // the model state before that edge
    task automatic tick(input bit ld, input bit pn, input logic [63:0] d);
        @(negedge clk);
        load_i      = ld;
        page_next_i = pn;
        data_i      = d;
        exp_q.push_back(model_out());
        model_step(ld, pn, d);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] need);
        compared++;
        if (got !== need) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, got, need);
        end
    endtask

    // Monitor: outputs are presented every clock
    obs_t mon_e, mon_a;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_a = {an_o, nibble_o, dp_o, page_o};
                compared++;
                if (mon_a !== mon_e) begin
                    mismatched++;
                    $display("FAIL scan_out @%0t: got an=%b nib=%h dp=%b page=%0d, expected an=%b nib=%h dp=%b page=%0d",
                             $time, mon_a.an, mon_a.nib, mon_a.dp, mon_a.page,
                             mon_e.an, mon_e.nib, mon_e.dp, mon_e.page);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "watchdog");
    end

    int found;

    initial begin
        rst_n       = 1'b0;
        load_i      = 1'b0;
        page_next_i = 1'b0;
        data_i      = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_an", 64'(an_o), 64'hF);
        check("reset_nibble", 64'(nibble_o), 64'h0);
        check("reset_dp", 64'(dp_o), 64'h1);
        check("reset_page", 64'(page_o), 64'h0);
        rst_n = 1'b1;

        // Idle: page steps must be ignored
        repeat (100) tick(1'b0, $urandom_range(0, 3) == 0, {$urandom(), $urandom()});

        // Load and display one scan plus a bit
        tick(1'b1, 1'b0, 64'h0123456789ABCDEF);
        repeat (40) tick(1'b0, 1'b0, {$urandom(), $urandom()});

        // Four page steps: 1, 2, 3, then wrap to 0
        for (int p = 0; p < 4; p++) begin
            tick(1'b0, 1'b1, {$urandom(), $urandom()});
            repeat (33) tick(1'b0, 1'b0, {$urandom(), $urandom()});
        end

        // Go to page 2, then simultaneous load and page step
        repeat (2) begin
            tick(1'b0, 1'b1, '0);
            repeat (5) tick(1'b0, 1'b0, '0);
        end
        tick(1'b1, 1'b1, 64'hFFFF_0000_FFFF_0000);
        repeat (40) tick(1'b0, 1'b0, {$urandom(), $urandom()});

        // Asynchronous reset while digit 2 is lit
        found = 0;
        for (int i = 0; i < 64 && found == 0; i++) begin
            tick(1'b0, 1'b0, '0);
            @(posedge clk);
            #3;
            if (an_o == 4'b1011) found = 1;
        end
        check("reach_an_1011", 64'(found), 64'h1);
        rst_n = 1'b0;
        #1;
        check("midreset_an", 64'(an_o), 64'hF);
        check("midreset_nibble", 64'(nibble_o), 64'h0);
        check("midreset_dp", 64'(dp_o), 64'h1);
        check("midreset_page", 64'(page_o), 64'h0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Stays idle until the next load
        repeat (20) tick(1'b0, $urandom_range(0, 2) == 0, {$urandom(), $urandom()});

        // Randomized traffic
        tick(1'b1, 1'b0, {$urandom(), $urandom()});
        repeat (3000) tick($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                           {$urandom(), $urandom()});
        tick(1'b0, 1'b0, '0);
        repeat (2) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
# hex_scan_ctrl

Time-multiplexing controller for a bank of common-anode seven-segment digits that displays a 64-bit DES block (plaintext, key or ciphertext) as 16 hex nibbles. It latches the block on a load strobe, pages through it DIGITS nibbles at a time, and drives one shared 4-bit nibble bus into the existing hex-to-segment decoder plus active-low digit enables. It sits between the DES core output registers and the board display pins.

## Interface
- DIGITS, 4: physical digits; legal values 1, 2, 4, 8, 16.
- SCAN_DIV, 1000: clocks per digit slot; must be ≥ 4.
- BLANK, 2: clocks at the start of each slot with all digits off (anti-ghosting); must be < SCAN_DIV.
- PAGE_DIV, 500: full scans per auto page step (used only with SEG_AUTO_PAGE_EN).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_i  in  64  block to display; nibble k = data_i[4k+3:4k].
- load_i  in  1  single-cycle strobe; latch data_i.
- page_next_i  in  1  single-cycle strobe; advance page (already debounced upstream).
- nibble_o  out  4  nibble for the segment decoder.
- an_o  out  DIGITS  digit enables, active-low.
- dp_o  out  1  decimal point, active-low.
- page_o  out  4  current page index.

## Operation
- Pages: NP = 16/DIGITS. Page p, digit d (d=0 rightmost) shows nibble p·DIGITS+d.
- Shadow register sh[63:0] captures data_i on load_i; the display never reads data_i directly.
- FSM states:
  - IDLE (after reset): all an_o high; load_i → SCAN.
  - SCAN: slot counter cnt runs 0..SCAN_DIV−1. On wrap, digit increments mod DIGITS. For cnt < BLANK, an_o is all ones; otherwise an_o[digit]=0 and all others 1.
  - No return to IDLE except by reset.
- nibble_o = sh[4(page·DIGITS+digit) +: 4] is valid for the whole slot, including the blank window.
- dp_o = 0 only when an_o[DIGITS−1] is active and page = 0 (marks the first page); otherwise 1.
- page_next_i: page ← page+1; page NP−1 wraps to 0. Ignored in IDLE.
- load_i in SCAN:
  - Reload sh and set page ← 0.
  - cnt and digit continue undisturbed (no scan restart).
- load_i and page_next_i in the same cycle: load wins, page = 0.
- Counters are sized to their ranges with no overflow beyond the stated wrap points.

## Timing
- All outputs are registered; every output follows the state/counter it depends on by 1 clock.
- Reset values: an_o all ones, nibble_o 0, dp_o 1, page_o 0, sh 0, cnt 0, digit 0, state IDLE.
- Load latency: load_i at edge n → state SCAN and sh valid after edge n. First enabled digit (digit 0, page 0) appears at edge n+1+BLANK.
- page_next_i at edge n → page_o and nibble_o reflect the new page after edge n+1.
- Full scan period = DIGITS·SCAN_DIV clocks.
- Reset mid-scan forces the reset values immediately (asynchronously); no partial digit is left enabled.

## Configuration
- SEG_AUTO_PAGE_EN defined:
  - A scan counter advances page automatically every PAGE_DIV complete scans (the digit DIGITS−1 → 0 wrap).
  - page_next_i also advances the page and clears the scan counter.
  - load_i clears the scan counter.
- SEG_AUTO_PAGE_EN not defined: page changes only on page_next_i or load_i, and no auto-page logic is synthesized.

## Test plan
Defaults for all scenarios: DIGITS=4, SCAN_DIV=8, BLANK=2, macro undefined unless stated.
- Reset, then idle for 100 clk → an_o=4'b1111, dp_o=1, page_o=0 throughout.
- load_i with data_i=64'h0123456789ABCDEF → the nibble_o sequence over one scan is F,E,D,C, with an_o=1110,1101,1011,0111 after 2 blank clocks per slot. dp_o=0 only during digit 3.
- Three page_next_i pulses → page_o goes 1,2,3 with nibbles {B,A,9,8},{7,6,5,4},{3,2,1,0}. A fourth pulse wraps page_o to 0.
- load_i and page_next_i asserted together on page 2 with data_i=64'hFFFF_0000_FFFF_0000 → page_o=0, nibble_o=0 on the next slot, and the digit sequence is unbroken.
- rst_n pulsed low while an_o=1011 → an_o=1111 immediately and the block stays in IDLE until the next load_i.
- SEG_AUTO_PAGE_EN defined, PAGE_DIV=2 → page_o increments every 64 clk and wraps 3→0.
